// File: rtl/tlp_tx_arb.sv
// Packet-boundary arbiter sharing the PCIe TX streaming port between the
// completion, master-request and root-port TLP source FIFOs.
module tlp_tx_arb #(
  parameter int unsigned C_CPL_PRIO     = 1,
  parameter int unsigned C_PKTCNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      TxEnable,
  input  logic                      CplTLPReady,
  input  logic [130:0]              CplFifoData,
  output logic                      CplFifoRdReq,
  input  logic                      MstTLPReady,
  input  logic [130:0]              MstFifoData,
  output logic                      MstFifoRdReq,
  input  logic                      RpTLPReady,
  input  logic [130:0]              TxRpFifoData,
  output logic                      TxRpFifoRdReq,
  output logic [127:0]              TxStData,
  output logic                      TxStSop,
  output logic                      TxStEop,
  output logic                      TxStEmpty,
  output logic                      TxStValid,
  input  logic                      TxStReady,
  output logic [1:0]                TxArbGrant,
  output logic [C_PKTCNT_WIDTH-1:0] TxPktCnt,
  output logic                      TxArbErr
);

  localparam int unsigned DATA_W   = 128;
  localparam bit          CPL_PRIO = (C_CPL_PRIO != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  localparam logic [1:0] G_CPL  = 2'd0;
  localparam logic [1:0] G_MST  = 2'd1;
  localparam logic [1:0] G_RP   = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  logic [0:0]                r_state, w_state_nxt;
  logic [1:0]                r_grant, w_grant_nxt;
  logic [1:0]                r_rr_last, w_rr_nxt;
  logic                      r_first, w_first_nxt;
  logic                      r_err, w_err_nxt;
  logic [DATA_W-1:0]         r_data;
  logic                      r_sop, r_eop, r_empty, r_valid;
  logic [C_PKTCNT_WIDTH-1:0] r_pktcnt;

  logic [2:0]   w_rdy;
  logic [1:0]   w_winner;
  logic [130:0] w_beat;
  logic         w_beat_sop, w_beat_eop;
  logic         w_out_ce, w_pop;

  assign w_rdy      = {RpTLPReady, MstTLPReady, CplTLPReady};
  assign w_out_ce   = ~r_valid | TxStReady;
  assign w_pop      = (r_state == S_XFER) & w_out_ce;
  assign w_beat_sop = w_beat[128];
  assign w_beat_eop = w_beat[129];

  // Winner: optional Cpl priority, else round-robin starting after the last winner
  always_comb begin
    w_winner = G_CPL;
    if (CPL_PRIO && CplTLPReady) begin
      w_winner = G_CPL;
    end else begin
      case (r_rr_last)
        G_CPL:   w_winner = w_rdy[1] ? G_MST : (w_rdy[2] ? G_RP  : G_CPL);
        G_MST:   w_winner = w_rdy[2] ? G_RP  : (w_rdy[0] ? G_CPL : G_MST);
        default: w_winner = w_rdy[0] ? G_CPL : (w_rdy[1] ? G_MST : G_RP);
      endcase
    end
  end

  always_comb begin
    case (r_grant)
      G_CPL:   w_beat = CplFifoData;
      G_MST:   w_beat = MstFifoData;
      default: w_beat = TxRpFifoData;
    endcase
  end

  assign CplFifoRdReq  = w_pop & (r_grant == G_CPL);
  assign MstFifoRdReq  = w_pop & (r_grant == G_MST);
  assign TxRpFifoRdReq = w_pop & (r_grant == G_RP);

  // Next-state logic; framing error checks sop against first-beat-of-grant
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_last;
    w_first_nxt = r_first;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (TxEnable && (w_rdy != 3'b000)) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = w_winner;
          w_rr_nxt    = w_winner;
          w_first_nxt = 1'b1;
        end
      end
      S_XFER: begin
        if (w_pop) begin
          w_first_nxt = 1'b0;
          if ((r_first && !w_beat_sop) || (!r_first && w_beat_sop)) begin
            w_err_nxt = 1'b1;
          end
          if (w_beat_eop) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = G_NONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= G_NONE;
      r_rr_last <= G_RP;
      r_first   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_last <= w_rr_nxt;
      r_first   <= w_first_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Output stage: loads the popped beat, or drains when the sink took the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_empty <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_out_ce) begin
      if (w_pop) begin
        r_data  <= w_beat[DATA_W-1:0];
        r_sop   <= w_beat_sop;
        r_eop   <= w_beat_eop;
        r_empty <= w_beat[130];
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pktcnt <= '0;
    end else if (r_valid && TxStReady && r_eop) begin
      r_pktcnt <= r_pktcnt + C_PKTCNT_WIDTH'(1);
    end
  end

  assign TxStData   = r_data;
  assign TxStSop    = r_sop;
  assign TxStEop    = r_eop;
  assign TxStEmpty  = r_empty;
  assign TxStValid  = r_valid;
  assign TxArbGrant = r_grant;
  assign TxPktCnt   = r_pktcnt;
  assign TxArbErr   = r_err;

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Directed bench for tlp_tx_arb: instance A (Cpl priority, 16-bit count) and
// instance B (round-robin, 2-bit count) share stimulus; sel picks whose pops drive the FIFO model.
module tb_tlp_tx_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic TxEnable = 1'b0;
  logic TxStReady = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic [130:0] fq [3][$];
  logic [130:0] head [3];
  logic         hv [3];
  logic [130:0] capA [$];
  logic [130:0] capB [$];

  logic a_crd, a_mrd, a_rrd, a_sop, a_eop, a_empty, a_valid, a_err;
  logic b_crd, b_mrd, b_rrd, b_sop, b_eop, b_empty, b_valid, b_err;
  logic [127:0] a_data, b_data;
  logic [1:0]   a_grant, b_grant;
  logic [15:0]  a_cnt;
  logic [1:0]   b_cnt;
  logic [2:0]   w_rd;

  int total = 0;
  int bad = 0;

  assign w_rd = sel ? {b_rrd, b_mrd, b_crd} : {a_rrd, a_mrd, a_crd};

  tlp_tx_arb #(.C_CPL_PRIO(1), .C_PKTCNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .TxEnable(TxEnable),
    .CplTLPReady(hv[0]), .CplFifoData(head[0]), .CplFifoRdReq(a_crd),
    .MstTLPReady(hv[1]), .MstFifoData(head[1]), .MstFifoRdReq(a_mrd),
    .RpTLPReady(hv[2]), .TxRpFifoData(head[2]), .TxRpFifoRdReq(a_rrd),
    .TxStData(a_data), .TxStSop(a_sop), .TxStEop(a_eop), .TxStEmpty(a_empty),
    .TxStValid(a_valid), .TxStReady(TxStReady), .TxArbGrant(a_grant),
    .TxPktCnt(a_cnt), .TxArbErr(a_err)
  );

  tlp_tx_arb #(.C_CPL_PRIO(0), .C_PKTCNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .TxEnable(TxEnable),
    .CplTLPReady(hv[0]), .CplFifoData(head[0]), .CplFifoRdReq(b_crd),
    .MstTLPReady(hv[1]), .MstFifoData(head[1]), .MstFifoRdReq(b_mrd),
    .RpTLPReady(hv[2]), .TxRpFifoData(head[2]), .TxRpFifoRdReq(b_rrd),
    .TxStData(b_data), .TxStSop(b_sop), .TxStEop(b_eop), .TxStEmpty(b_empty),
    .TxStValid(b_valid), .TxStReady(TxStReady), .TxArbGrant(b_grant),
    .TxPktCnt(b_cnt), .TxArbErr(b_err)
  );

  // Show-ahead FIFO model plus capture of beats accepted by the sink
  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (w_rd[s] && fq[s].size() > 0) void'(fq[s].pop_front());
      hv[s]   <= (fq[s].size() > 0);
      head[s] <= (fq[s].size() > 0) ? fq[s][0] : '0;
    end
    if (a_valid && TxStReady) capA.push_back({a_empty, a_eop, a_sop, a_data});
    if (b_valid && TxStReady) capB.push_back({b_empty, b_eop, b_sop, b_data});
  end

  function automatic logic [130:0] mk(input int id, input logic sop, input logic eop);
    return {1'b0, eop, sop, 128'(id)};
  endfunction

  task automatic chk(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b1;
    sel = s;
    TxEnable = 1'b1;
    TxStReady = 1'b1;
    for (int q = 0; q < 3; q++) fq[q].delete();
    capA.delete();
    capB.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  logic         sv, srdy;
  logic [130:0] sdata;
  logic [3:0]   pat;
  logic [1:0]   gseq [7];

  initial begin
    for (int s = 0; s < 3; s++) begin
      hv[s] = 1'b0;
      head[s] = '0;
    end
    step();

    // Reset values and a 3-beat Cpl packet
    do_reset(1'b0);
    chk("rst_valid", a_valid, 0);
    chk("rst_grant", a_grant, 3);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_err", a_err, 0);
    chk("rst_data", {a_empty, a_eop, a_sop, a_data}, 0);
    chk("rst_rd", {a_rrd, a_mrd, a_crd}, 0);
    fq[0].push_back(mk('h01, 1, 0));
    fq[0].push_back(mk('h02, 0, 0));
    fq[0].push_back(mk('h03, 0, 1));
    step();
    chk("t1_idle_grant", a_grant, 3);
    chk("t1_idle_rd", a_crd, 0);
    step();
    chk("t1_grant", a_grant, 0);
    chk("t1_rd1", {a_rrd, a_mrd, a_crd}, 3'b001);
    chk("t1_valid0", a_valid, 0);
    step();
    chk("t1_rd2", a_crd, 1);
    chk("t1_beat1", {a_valid, a_empty, a_eop, a_sop, a_data}, {1'b1, mk('h01, 1, 0)});
    step();
    chk("t1_rd3", a_crd, 1);
    chk("t1_beat2", {a_valid, a_empty, a_eop, a_sop, a_data}, {1'b1, mk('h02, 0, 0)});
    step();
    chk("t1_rd_off", a_crd, 0);
    chk("t1_grant_none", a_grant, 3);
    chk("t1_beat3", {a_valid, a_empty, a_eop, a_sop, a_data}, {1'b1, mk('h03, 0, 1)});
    step();
    chk("t1_valid_end", a_valid, 0);
    chk("t1_cnt", a_cnt, 1);

    // Cpl priority: Mst never granted while Cpl ready
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      fq[0].push_back(mk('h100 + i, 1, 1));
      fq[1].push_back(mk('h200 + i, 1, 1));
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (hv[0]) chk("t2_no_mst", {a_grant == 2'd1, a_mrd}, 0);
    end
    chk("t2_cpl_left", 131'(fq[0].size()), 2);
    chk("t2_mst_left", 131'(fq[1].size()), 6);

    // Round-robin grant order and 2-bit packet counter wrap
    do_reset(1'b1);
    fq[0].push_back(mk('h10, 1, 1));
    fq[0].push_back(mk('h11, 1, 1));
    fq[1].push_back(mk('h20, 1, 1));
    fq[1].push_back(mk('h21, 1, 1));
    fq[2].push_back(mk('h30, 1, 1));
    gseq = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
    step();
    chk("t3_idle", b_grant, 3);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t3_grant%0d", i), b_grant, gseq[i]);
    end
    for (int i = 0; i < 8; i++) step();
    chk("t3_cnt_wrap", b_cnt, 1);
    chk("t3_ncap", 131'(capB.size()), 5);
    if (capB.size() == 5) begin
      chk("t3_ord0", capB[0], mk('h10, 1, 1));
      chk("t3_ord1", capB[1], mk('h20, 1, 1));
      chk("t3_ord2", capB[2], mk('h30, 1, 1));
      chk("t3_ord3", capB[3], mk('h11, 1, 1));
      chk("t3_ord4", capB[4], mk('h21, 1, 1));
    end
    chk("t3_err", b_err, 0);

    // Rp 4-beat packet under sink backpressure
    do_reset(1'b0);
    fq[2].push_back(mk('h40, 1, 0));
    fq[2].push_back(mk('h41, 0, 0));
    fq[2].push_back(mk('h42, 0, 0));
    fq[2].push_back(mk('h43, 0, 1));
    pat = 4'b1001;
    for (int i = 0; i < 30; i++) begin
      TxStReady = pat[i % 4];
      #1;
      if (a_valid && !TxStReady) chk("t4_stall_rd", a_rrd, 0);
      sv = a_valid;
      srdy = TxStReady;
      sdata = {a_empty, a_eop, a_sop, a_data};
      step();
      if (sv && !srdy) chk("t4_hold", {a_valid, a_empty, a_eop, a_sop, a_data}, {1'b1, sdata});
    end
    TxStReady = 1'b1;
    chk("t4_ncap", 131'(capA.size()), 4);
    if (capA.size() == 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("t4_beat%0d", i), capA[i], mk('h40 + i, i == 0, i == 3));
    end
    chk("t4_cnt", a_cnt, 1);

    // TxEnable dropped mid-packet: packet finishes, no new grant until re-enabled
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) fq[1].push_back(mk('h50 + i, i == 0, i == 3));
    fq[1].push_back(mk('h54, 1, 1));
    step();
    step();
    chk("t5_grant", a_grant, 1);
    step();
    step();
    TxEnable = 1'b0;
    step();
    chk("t5_rd3", a_mrd, 1);
    step();
    chk("t5_done", a_grant, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_hold_off", {a_grant, a_mrd}, {2'd3, 1'b0});
    end
    chk("t5_ncap", 131'(capA.size()), 4);
    if (capA.size() == 4) chk("t5_last", capA[3], mk('h53, 0, 1));
    TxEnable = 1'b1;
    step();
    chk("t5_regrant", a_grant, 1);

    // Framing error: second beat carries sop
    do_reset(1'b0);
    fq[0].push_back(mk('h60, 1, 0));
    fq[0].push_back(mk('h61, 1, 0));
    fq[0].push_back(mk('h62, 0, 1));
    step();
    step();
    step();
    chk("t6_err_before", a_err, 0);
    step();
    chk("t6_err_set", a_err, 1);
    for (int i = 0; i < 3; i++) step();
    chk("t6_ncap", 131'(capA.size()), 3);
    if (capA.size() == 3) chk("t6_fwd", capA[1], mk('h61, 1, 0));
    fq[0].push_back(mk('h63, 1, 1));
    for (int i = 0; i < 5; i++) step();
    chk("t6_err_sticky", a_err, 1);
    chk("t6_cnt", a_cnt, 2);
    do_reset(1'b0);
    chk("t6_err_clr", a_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
